// File: rtl/store_size_unit_if.sv
// Bus between the control FSM / data memory and the store-size unit.
// master: the side that issues store requests and models the memory port.
// slave:  the store-size unit itself.
interface store_size_unit_if;
  logic        start;
  logic [1:0]  ss_control;
  logic [31:0] addr;
  logic [31:0] regB_out;
  logic [31:0] mem_data_in;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_out;
  logic        mem_rd;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        ss_error;

  modport master (
    output start, ss_control, addr, regB_out, mem_data_in,
    input  mem_addr, mem_data_out, mem_rd, mem_wr, busy, done, ss_error
  );

  modport slave (
    input  start, ss_control, addr, regB_out, mem_data_in,
    output mem_addr, mem_data_out, mem_rd, mem_wr, busy, done, ss_error
  );
endinterface

// File: rtl/store_size_unit.sv
// Store-size unit: word stores go straight to memory, halfword and byte
// stores do a read-modify-write so only the addressed lanes change.
// Misaligned or illegal requests finish with an error pulse and no strobe.
//
// state | meaning
// IDLE  | waiting for start
// READ  | mem_rd strobe for the addressed word
// WAIT  | memory read latency, MEM_LAT cycles, counted down
// WRITE | mem_wr strobe with the final word
// DONE  | done pulse
// ERR   | done + ss_error pulse, memory untouched
module store_size_unit #(
  parameter int MEM_LAT = 1
) (
  input logic            clk,
  input logic            reset,
  store_size_unit_if.slave bus
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] data_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_data_q;
  logic [CW-1:0] wait_cnt;

  logic        req_err;
  logic        wait_tc;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;

  // Misaligned SW/SH or the reserved size code are rejected up front.
  always_comb begin
    req_err = 1'b0;
    case (bus.ss_control)
      2'b00:   req_err = (bus.addr[1:0] != 2'b00);
      2'b01:   req_err = bus.addr[0];
      2'b10:   req_err = 1'b0;
      default: req_err = 1'b1;
    endcase
  end

  assign wait_tc = (wait_cnt == '0);

  // Lane mask and replicated operand for the merge; SW never reaches the merge.
  always_comb begin
    lane_mask = 32'h0;
    lane_data = 32'h0;
    if (size_q == 2'b10) begin
      lane_mask = 32'h0000_00ff << {off_q, 3'b000};
      lane_data = {4{data_q[7:0]}};
    end else begin
      lane_mask = off_q[1] ? 32'hffff_0000 : 32'h0000_ffff;
      lane_data = {2{data_q[15:0]}};
    end
    merged = (bus.mem_data_in & ~lane_mask) | (lane_data & lane_mask);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request capture, latency down-counter and write-word register.
  always_ff @(posedge clk) begin
    if (reset) begin
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      data_q     <= 32'h0;
      mem_addr_q <= 32'h0;
      mem_data_q <= 32'h0;
      wait_cnt   <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        size_q     <= bus.ss_control;
        off_q      <= bus.addr[1:0];
        data_q     <= bus.regB_out;
        mem_addr_q <= {bus.addr[31:2], 2'b00};
        if (bus.ss_control == 2'b00 && !req_err) mem_data_q <= bus.regB_out;
      end
      if (state == READ) begin
        wait_cnt <= CW'(MEM_LAT - 1);
      end else if (state == WAIT && !wait_tc) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (state == WAIT && wait_tc) mem_data_q <= merged;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_next   = state;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    bus.ss_error = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          if (req_err)                      state_next = ERR;
          else if (bus.ss_control == 2'b00) state_next = WRITE;
          else                              state_next = READ;
        end
      end
      READ: begin
        bus.mem_rd = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (wait_tc) state_next = WRITE;
      end
      WRITE: begin
        bus.mem_wr = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        bus.done     = 1'b1;
        bus.ss_error = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        bus.busy   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data_out = mem_data_q;

endmodule

// File: tb/tb_store_size_unit.sv
// Bench for store_size_unit: two instances (MEM_LAT=1 and MEM_LAT=3) run the
// same requests side by side against their own memory models; a byte-level
// reference model predicts timing and the stored word.
module tb_store_size_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  store_size_unit_if b0();
  store_size_unit_if b1();

  store_size_unit #(.MEM_LAT(1)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  store_size_unit #(.MEM_LAT(3)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  logic        start = 1'b0;
  logic [1:0]  ss_ctl = 2'b00;
  logic [31:0] addr_in = 32'h0;
  logic [31:0] regb = 32'h0;

  assign b0.start = start;      assign b1.start = start;
  assign b0.ss_control = ss_ctl; assign b1.ss_control = ss_ctl;
  assign b0.addr = addr_in;     assign b1.addr = addr_in;
  assign b0.regB_out = regb;    assign b1.regB_out = regb;

  // memory models: 256 words, read data valid for exactly one cycle, MEM_LAT after mem_rd
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  logic [31:0] ref_mem [256];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = 8'h0;
  logic [31:0] poke_dat = 32'h0;
  logic        p0_v;
  logic [31:0] p0_d;
  logic [2:0]  p1_v;
  logic [31:0] p1_d [3];

  always @(posedge clk) begin
    if (poke_en) begin
      mem0[poke_idx] <= poke_dat;
      mem1[poke_idx] <= poke_dat;
    end
    if (b0.mem_wr) mem0[b0.mem_addr[9:2]] <= b0.mem_data_out;
    if (b1.mem_wr) mem1[b1.mem_addr[9:2]] <= b1.mem_data_out;
    p0_v    <= b0.mem_rd;
    p0_d    <= mem0[b0.mem_addr[9:2]];
    p1_v    <= {p1_v[1:0], b1.mem_rd};
    p1_d[0] <= mem1[b1.mem_addr[9:2]];
    p1_d[1] <= p1_d[0];
    p1_d[2] <= p1_d[1];
  end

  assign b0.mem_data_in = (p0_v === 1'b1)    ? p0_d    : 32'hDEAD_BEEF;
  assign b1.mem_data_in = (p1_v[2] === 1'b1) ? p1_d[2] : 32'hDEAD_BEEF;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference: legality from size/alignment, result from byte lanes
  function automatic bit ref_err(input logic [1:0] ctl, input logic [31:0] a);
    int size;
    if (ctl == 2'b11) return 1'b1;
    size = 4 >> ctl;
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] ctl,
                                            input logic [31:0] a, input logic [31:0] d);
    logic [7:0] b [4];
    logic [7:0] s [4];
    int off;
    int size;
    logic [31:0] r;
    off  = a % 4;
    size = 4 >> ctl;
    for (int i = 0; i < 4; i++) begin
      b[i] = old[8*i +: 8];
      s[i] = d[8*i +: 8];
    end
    for (int i = 0; i < size; i++) b[off + i] = s[i];
    for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = idx[7:0];
    poke_dat = val;
    ref_mem[idx] = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic do_txn(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] d,
                        input bit pulse3);
    int lat [2];
    int e_rd_n, e_wr_n, e_done_c [2], e_wr_c [2], e_busy [2];
    bit err;
    int idx;
    logic [31:0] e_word;
    int rd_n [2], rd_c [2], wr_n [2], wr_c [2], done_n [2], done_c [2], err_n [2], busy_n [2], viol [2];
    logic [31:0] wr_d [2], wr_a [2];
    logic [1:0] rd_v, wr_v, dn_v, er_v, bz_v;
    int c_end;
    lat[0] = 1; lat[1] = 3;
    err = ref_err(ctl, a);
    idx = int'(a[9:2]);
    e_word = ref_store(ref_mem[idx], ctl, a, d);
    for (int i = 0; i < 2; i++) begin
      if (err) begin
        e_wr_c[i] = 0; e_done_c[i] = 1; e_busy[i] = 1;
      end else if (ctl == 2'b00) begin
        e_wr_c[i] = 1; e_done_c[i] = 2; e_busy[i] = 2;
      end else begin
        e_wr_c[i] = 2 + lat[i]; e_done_c[i] = 3 + lat[i]; e_busy[i] = 3 + lat[i];
      end
      rd_n[i] = 0; rd_c[i] = 0; wr_n[i] = 0; wr_c[i] = 0; done_n[i] = 0; done_c[i] = 0;
      err_n[i] = 0; busy_n[i] = 0; viol[i] = 0; wr_d[i] = 32'h0; wr_a[i] = 32'h0;
    end
    e_rd_n = (!err && ctl != 2'b00) ? 1 : 0;
    e_wr_n = err ? 0 : 1;
    c_end = e_done_c[1];
    @(negedge clk);
    start = 1'b1; ss_ctl = ctl; addr_in = a; regb = d;
    for (int c = 1; c <= c_end; c++) begin
      @(negedge clk);
      start = pulse3 && (c == 3);
      ss_ctl = 2'($urandom); addr_in = $urandom; regb = $urandom;
      rd_v = {b1.mem_rd, b0.mem_rd};
      wr_v = {b1.mem_wr, b0.mem_wr};
      dn_v = {b1.done, b0.done};
      er_v = {b1.ss_error, b0.ss_error};
      bz_v = {b1.busy, b0.busy};
      for (int i = 0; i < 2; i++) begin
        if (rd_v[i]) begin rd_n[i]++; rd_c[i] = c; end
        if (wr_v[i]) begin
          wr_n[i]++; wr_c[i] = c;
          wr_d[i] = i ? b1.mem_data_out : b0.mem_data_out;
          wr_a[i] = i ? b1.mem_addr : b0.mem_addr;
        end
        if (dn_v[i]) begin done_n[i]++; done_c[i] = c; end
        if (er_v[i]) err_n[i]++;
        if (bz_v[i]) busy_n[i]++;
        if ((int'(rd_v[i]) + int'(wr_v[i]) + int'(dn_v[i]) > 1) || (er_v[i] && !dn_v[i])) viol[i]++;
      end
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd_n[%0d]", i), rd_n[i], e_rd_n);
      if (e_rd_n != 0) chk($sformatf("rd_cyc[%0d]", i), rd_c[i], 1);
      chk($sformatf("wr_n[%0d]", i), wr_n[i], e_wr_n);
      chk($sformatf("wr_cyc[%0d]", i), wr_c[i], e_wr_c[i]);
      chk($sformatf("done_n[%0d]", i), done_n[i], 1);
      chk($sformatf("done_cyc[%0d]", i), done_c[i], e_done_c[i]);
      chk($sformatf("err_n[%0d]", i), err_n[i], err ? 1 : 0);
      chk($sformatf("busy_n[%0d]", i), busy_n[i], e_busy[i]);
      chk($sformatf("excl[%0d]", i), viol[i], 0);
      chk($sformatf("addr_hold[%0d]", i), i ? b1.mem_addr : b0.mem_addr, {a[31:2], 2'b00});
      if (!err) begin
        chk($sformatf("wr_data[%0d]", i), wr_d[i], e_word);
        chk($sformatf("wr_addr[%0d]", i), wr_a[i], {a[31:2], 2'b00});
        chk($sformatf("data_hold[%0d]", i), i ? b1.mem_data_out : b0.mem_data_out, e_word);
      end
    end
    if (!err) ref_mem[idx] = e_word;
  endtask

  task automatic reset_during_wait();
    @(negedge clk);
    start = 1'b1; ss_ctl = 2'b10; addr_in = 32'h42; regb = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_rd", {b1.mem_rd, b0.mem_rd}, 2'b00);
    chk("rst_wr", {b1.mem_wr, b0.mem_wr}, 2'b00);
    chk("rst_busy", {b1.busy, b0.busy}, 2'b00);
    chk("rst_done", {b1.done, b0.done, b1.ss_error, b0.ss_error}, 4'b0);
    chk("rst_addr0", b0.mem_addr, 32'h0);
    chk("rst_addr1", b1.mem_addr, 32'h0);
    repeat (5) @(negedge clk);
    chk("rst_mem0", mem0[16], ref_mem[16]);
    chk("rst_mem1", mem1[16], ref_mem[16]);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 256; i++) poke(i, $urandom);
    @(negedge clk);
    chk("reset_out0", {b0.mem_rd, b0.mem_wr, b0.busy, b0.done, b0.ss_error}, 5'b0);
    chk("reset_out1", {b1.mem_rd, b1.mem_wr, b1.busy, b1.done, b1.ss_error}, 5'b0);
    chk("reset_addr", b0.mem_addr | b1.mem_addr, 32'h0);
    chk("reset_data", b0.mem_data_out | b1.mem_data_out, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    do_txn(2'b00, 32'h40, 32'h1234_5678, 1'b0);
    poke(16, 32'hAABB_CCDD);
    do_txn(2'b10, 32'h42, 32'h1234_5678, 1'b0);
    chk("sb_plan", ref_mem[16], 32'hAA78_CCDD);
    poke(16, 32'hAABB_CCDD);
    do_txn(2'b01, 32'h42, 32'h1234_5678, 1'b0);
    chk("sh_hi_plan", ref_mem[16], 32'h5678_CCDD);
    poke(16, 32'hAABB_CCDD);
    do_txn(2'b01, 32'h40, 32'h1234_5678, 1'b0);
    chk("sh_lo_plan", ref_mem[16], 32'hAABB_5678);
    do_txn(2'b01, 32'h43, 32'h1234_5678, 1'b0);
    do_txn(2'b00, 32'h42, 32'h1234_5678, 1'b0);
    do_txn(2'b11, 32'h40, 32'h1234_5678, 1'b0);

    reset_during_wait();
    do_txn(2'b00, 32'h44, 32'hCAFE_F00D, 1'b0);
    do_txn(2'b01, 32'h82, 32'h0000_BEEF, 1'b1);

    for (int n = 0; n < 80; n++) begin
      logic [1:0]  c;
      logic [31:0] a;
      logic [31:0] d;
      c = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 1023));
      d = $urandom;
      do_txn(c, a, d, (c != 2'b00) && !ref_err(c, a) && ($urandom_range(0, 2) == 0));
    end

    for (int i = 0; i < 256; i++) begin
      if (mem0[i] !== ref_mem[i] || mem1[i] !== ref_mem[i])
        chk($sformatf("mem[%0d]", i), (mem0[i] !== ref_mem[i]) ? mem0[i] : mem1[i], ref_mem[i]);
    end
    chk("mem_final0", mem0[17], ref_mem[17]);
    chk("mem_final1", mem1[17], ref_mem[17]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
